// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types: decoded entry record, exception record and sizing constants.
package scoreboard_pkg;

   localparam int unsigned NR_SB_ENTRIES = 8;
   localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

   typedef enum logic [2:0] {
      FU_NONE,
      FU_LOAD,
      FU_STORE,
      FU_ALU,
      FU_CTRL_FLOW,
      FU_MULT,
      FU_CSR
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception;

   typedef struct packed {
      logic [63:0]              pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      fu_t                      fu;
      logic [6:0]               op;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic [63:0]              result;
      logic                     valid;
      logic                     in_flight;
      exception                 ex;
   } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order allocate, out-of-order complete scoreboard: circular entry buffer,
// writeback collection by transaction ID, in-order commit and operand lookup.
module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int unsigned NR_ENTRIES    = NR_SB_ENTRIES,
   parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   output logic                     full_o,
   input  scoreboard_entry          decoded_instr_i,
   input  logic                     decoded_instr_valid_i,
   output logic                     decoded_instr_ack_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o,
   input  logic                     wb_valid_i,
   input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i,
   input  logic [63:0]              wb_result_i,
   input  exception                 wb_ex_i,
   output scoreboard_entry          commit_instr_o,
   output logic                     commit_valid_o,
   input  logic                     commit_ack_i,
   input  logic [4:0]               rs1_i,
   input  logic [4:0]               rs2_i,
   output logic                     rs1_busy_o,
   output logic                     rs2_busy_o,
   output logic                     rs1_fwd_valid_o,
   output logic                     rs2_fwd_valid_o,
   output logic [63:0]              rs1_o,
   output logic [63:0]              rs2_o
);

   localparam int unsigned CNT_BITS = TRANS_ID_BITS + 1;

   typedef scoreboard_entry sb_mem_t [NR_ENTRIES];

   typedef struct packed {
      logic        found;
      logic        valid;
      logic [63:0] result;
   } lookup_t;

   sb_mem_t                  mem_q, mem_d;
   logic [NR_ENTRIES-1:0]    occ_q, occ_d;
   logic [TRANS_ID_BITS-1:0] head_q, head_d;
   logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
   logic [CNT_BITS-1:0]      cnt_q, cnt_d;

   logic    push;
   logic    commit_fire;
   lookup_t lk1, lk2;

   // Walk from head towards tail; the last hit is the youngest producer of rs.
   function automatic lookup_t find_youngest(input sb_mem_t               mem,
                                             input logic [NR_ENTRIES-1:0] occ,
                                             input logic [TRANS_ID_BITS-1:0] head,
                                             input logic [4:0]            rs);
      lookup_t                  r;
      logic [TRANS_ID_BITS-1:0] idx;
      r = '0;
      if (rs != 5'd0) begin
         for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            idx = head + TRANS_ID_BITS'(i);
            if (occ[idx] && mem[idx].rd == rs) begin
               r.found  = 1'b1;
               r.valid  = mem[idx].valid;
               r.result = mem[idx].result;
            end
         end
      end
      return r;
   endfunction

   assign full_o              = (cnt_q == CNT_BITS'(NR_ENTRIES));
   assign trans_id_o          = tail_q;
   assign commit_instr_o      = mem_q[head_q];
   assign commit_valid_o      = occ_q[head_q] & mem_q[head_q].valid;
   assign push                = decoded_instr_valid_i & ~full_o & ~flush_i;
   assign decoded_instr_ack_o = push;
   assign commit_fire         = commit_ack_i & commit_valid_o & ~flush_i;

   always_comb begin
      mem_d  = mem_q;
      occ_d  = occ_q;
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         occ_d  = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) begin
            mem_d[tail_q]           = decoded_instr_i;
            mem_d[tail_q].valid     = 1'b0;
            mem_d[tail_q].in_flight = 1'b1;
            occ_d[tail_q]           = 1'b1;
            tail_d                  = tail_q + 1'b1;
         end
         // The pushed slot is never occupied, so push and writeback cannot collide.
         if (wb_valid_i && occ_q[wb_trans_id_i]) begin
            mem_d[wb_trans_id_i].result    = wb_result_i;
            mem_d[wb_trans_id_i].ex        = wb_ex_i;
            mem_d[wb_trans_id_i].valid     = 1'b1;
            mem_d[wb_trans_id_i].in_flight = 1'b0;
         end
         if (commit_fire) begin
            occ_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
         end
         cnt_d = cnt_q + CNT_BITS'(push) - CNT_BITS'(commit_fire);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            mem_q[i] <= '0;
         end
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      lk1             = find_youngest(mem_q, occ_q, head_q, rs1_i);
      lk2             = find_youngest(mem_q, occ_q, head_q, rs2_i);
      rs1_busy_o      = lk1.found & ~lk1.valid;
      rs2_busy_o      = lk2.found & ~lk2.valid;
      rs1_fwd_valid_o = lk1.found & lk1.valid;
      rs2_fwd_valid_o = lk2.found & lk2.valid;
      rs1_o           = lk1.result;
      rs2_o           = lk2.result;
   end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: push/lookup, out-of-order writeback,
// full/wrap, youngest-producer forwarding, flush and mid-stream reset.
module tb_scoreboard;
   import scoreboard_pkg::*;

   localparam int unsigned N  = 8;
   localparam int unsigned TB = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            full_o;
   scoreboard_entry decoded_instr_i;
   logic            decoded_instr_valid_i;
   logic            decoded_instr_ack_o;
   logic [TB-1:0]   trans_id_o;
   logic            wb_valid_i;
   logic [TB-1:0]   wb_trans_id_i;
   logic [63:0]     wb_result_i;
   exception        wb_ex_i;
   scoreboard_entry commit_instr_o;
   logic            commit_valid_o;
   logic            commit_ack_i;
   logic [4:0]      rs1_i, rs2_i;
   logic            rs1_busy_o, rs2_busy_o;
   logic            rs1_fwd_valid_o, rs2_fwd_valid_o;
   logic [63:0]     rs1_o, rs2_o;

   int vecs = 0;
   int errs = 0;

   scoreboard #(.NR_ENTRIES(N)) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i),
      .full_o                (full_o),
      .decoded_instr_i       (decoded_instr_i),
      .decoded_instr_valid_i (decoded_instr_valid_i),
      .decoded_instr_ack_o   (decoded_instr_ack_o),
      .trans_id_o            (trans_id_o),
      .wb_valid_i            (wb_valid_i),
      .wb_trans_id_i         (wb_trans_id_i),
      .wb_result_i           (wb_result_i),
      .wb_ex_i               (wb_ex_i),
      .commit_instr_o        (commit_instr_o),
      .commit_valid_o        (commit_valid_o),
      .commit_ack_i          (commit_ack_i),
      .rs1_i                 (rs1_i),
      .rs2_i                 (rs2_i),
      .rs1_busy_o            (rs1_busy_o),
      .rs2_busy_o            (rs2_busy_o),
      .rs1_fwd_valid_o       (rs1_fwd_valid_o),
      .rs2_fwd_valid_o       (rs2_fwd_valid_o),
      .rs1_o                 (rs1_o),
      .rs2_o                 (rs2_o)
   );

   always #5 clk = ~clk;

   function automatic scoreboard_entry mk(input logic [4:0] rd);
      scoreboard_entry e;
      e    = '0;
      e.fu = FU_ALU;
      e.rd = rd;
      e.pc = 64'h1000 + {59'd0, rd};
      return e;
   endfunction

   // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_i               = 1'b0;
      decoded_instr_valid_i = 1'b0;
      decoded_instr_i       = '0;
      wb_valid_i            = 1'b0;
      wb_trans_id_i         = '0;
      wb_result_i           = '0;
      wb_ex_i               = '0;
      commit_ack_i          = 1'b0;
      rs1_i                 = 5'd0;
      rs2_i                 = 5'd0;
   endtask

   task automatic push(input logic [4:0] rd);
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i       = mk(rd);
      cyc();
      decoded_instr_valid_i = 1'b0;
   endtask

   task automatic wb(input logic [TB-1:0] id, input logic [63:0] res);
      wb_valid_i    = 1'b1;
      wb_trans_id_i = id;
      wb_result_i   = res;
      cyc();
      wb_valid_i    = 1'b0;
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_ni = 1'b0;
      cyc();
      cyc();
      rst_ni = 1'b1;
      rs1_i  = 5'd1;
      rs2_i  = 5'd0;
      #1;
      vecs++; if (full_o !== 1'b0) begin errs++; $display("FAIL reset_full got=%b exp=0", full_o); end
      vecs++; if (commit_valid_o !== 1'b0) begin errs++; $display("FAIL reset_commit_valid got=%b exp=0", commit_valid_o); end
      vecs++; if (decoded_instr_ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack got=%b exp=0", decoded_instr_ack_o); end
      vecs++; if (rs1_busy_o !== 1'b0 || rs1_fwd_valid_o !== 1'b0) begin errs++; $display("FAIL reset_rs1 got busy=%b fwd=%b exp 0/0", rs1_busy_o, rs1_fwd_valid_o); end
      vecs++; if (trans_id_o !== 3'd0) begin errs++; $display("FAIL reset_trans_id got=%0d exp=0", trans_id_o); end
   endtask

   task automatic test_push_busy();
      for (int k = 0; k < 3; k++) begin
         decoded_instr_valid_i = 1'b1;
         decoded_instr_i       = mk(5'(k + 1));
         #1;
         vecs++; if (trans_id_o !== 3'(k)) begin errs++; $display("FAIL push_trans_id[%0d] got=%0d exp=%0d", k, trans_id_o, k); end
         vecs++; if (decoded_instr_ack_o !== 1'b1) begin errs++; $display("FAIL push_ack[%0d] got=%b exp=1", k, decoded_instr_ack_o); end
         cyc();
      end
      decoded_instr_valid_i = 1'b0;
      rs1_i = 5'd2;
      rs2_i = 5'd4;
      #1;
      vecs++; if (commit_valid_o !== 1'b0) begin errs++; $display("FAIL push_commit_valid got=%b exp=0", commit_valid_o); end
      vecs++; if (rs1_busy_o !== 1'b1 || rs1_fwd_valid_o !== 1'b0) begin errs++; $display("FAIL push_rs1_busy got busy=%b fwd=%b exp 1/0", rs1_busy_o, rs1_fwd_valid_o); end
      vecs++; if (rs2_busy_o !== 1'b0) begin errs++; $display("FAIL push_rs2_free got=%b exp=0", rs2_busy_o); end
   endtask

   task automatic test_ooo_commit();
      wb(3'd1, 64'hAB);
      #1;
      vecs++; if (commit_valid_o !== 1'b0) begin errs++; $display("FAIL ooo_head_not_ready got=%b exp=0", commit_valid_o); end
      vecs++; if (rs1_fwd_valid_o !== 1'b1 || rs1_o !== 64'hAB) begin errs++; $display("FAIL ooo_fwd_rd2 got fwd=%b val=%h exp 1/ab", rs1_fwd_valid_o, rs1_o); end
      wb(3'd0, 64'h11);
      #1;
      vecs++; if (commit_valid_o !== 1'b1 || commit_instr_o.result !== 64'h11 || commit_instr_o.rd !== 5'd1) begin
         errs++; $display("FAIL ooo_commit0 got v=%b res=%h rd=%0d exp 1/11/1", commit_valid_o, commit_instr_o.result, commit_instr_o.rd); end
      commit_ack_i = 1'b1;
      cyc();
      commit_ack_i = 1'b0;
      #1;
      vecs++; if (commit_valid_o !== 1'b1 || commit_instr_o.result !== 64'hAB || commit_instr_o.rd !== 5'd2) begin
         errs++; $display("FAIL ooo_commit1 got v=%b res=%h rd=%0d exp 1/ab/2", commit_valid_o, commit_instr_o.result, commit_instr_o.rd); end
      commit_ack_i = 1'b1;
      cyc();
      commit_ack_i = 1'b0;
      #1;
      vecs++; if (commit_valid_o !== 1'b0 || commit_instr_o.rd !== 5'd3) begin errs++; $display("FAIL ooo_head2_pending got v=%b rd=%0d exp 0/3", commit_valid_o, commit_instr_o.rd); end
      // Ack without valid must not advance head.
      commit_ack_i = 1'b1;
      cyc();
      commit_ack_i = 1'b0;
      wb(3'd2, 64'h33);
      #1;
      vecs++; if (commit_valid_o !== 1'b1 || commit_instr_o.result !== 64'h33) begin errs++; $display("FAIL ooo_ack_ignored got v=%b res=%h exp 1/33", commit_valid_o, commit_instr_o.result); end
   endtask

   task automatic test_full_wrap();
      do_flush();
      for (int k = 0; k < 8; k++) begin
         vecs++; if (trans_id_o !== 3'(k)) begin errs++; $display("FAIL full_trans_id[%0d] got=%0d exp=%0d", k, trans_id_o, k); end
         push(5'(10 + k));
      end
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i       = mk(5'd20);
      #1;
      vecs++; if (full_o !== 1'b1) begin errs++; $display("FAIL full_flag got=%b exp=1", full_o); end
      vecs++; if (decoded_instr_ack_o !== 1'b0) begin errs++; $display("FAIL full_ninth_ack got=%b exp=0", decoded_instr_ack_o); end
      wb(3'd0, 64'h100);
      decoded_instr_valid_i = 1'b1;
      commit_ack_i          = 1'b1;
      #1;
      vecs++; if (commit_valid_o !== 1'b1 || decoded_instr_ack_o !== 1'b0) begin errs++; $display("FAIL full_commit_push got cv=%b ack=%b exp 1/0", commit_valid_o, decoded_instr_ack_o); end
      cyc();
      commit_ack_i = 1'b0;
      #1;
      vecs++; if (full_o !== 1'b0 || decoded_instr_ack_o !== 1'b1 || trans_id_o !== 3'd0) begin
         errs++; $display("FAIL full_wrap_push got full=%b ack=%b tid=%0d exp 0/1/0", full_o, decoded_instr_ack_o, trans_id_o); end
      cyc();
      decoded_instr_valid_i = 1'b0;
      #1;
      vecs++; if (full_o !== 1'b1 || trans_id_o !== 3'd1) begin errs++; $display("FAIL full_after_wrap got full=%b tid=%0d exp 1/1", full_o, trans_id_o); end
   endtask

   task automatic test_fwd_youngest();
      do_flush();
      push(5'd5);
      push(5'd5);
      wb(3'd0, 64'h5);
      rs1_i = 5'd5;
      rs2_i = 5'd0;
      #1;
      vecs++; if (rs1_busy_o !== 1'b1 || rs1_fwd_valid_o !== 1'b0) begin errs++; $display("FAIL fwd_young_pending got busy=%b fwd=%b exp 1/0", rs1_busy_o, rs1_fwd_valid_o); end
      wb(3'd1, 64'h7);
      #1;
      vecs++; if (rs1_busy_o !== 1'b0 || rs1_fwd_valid_o !== 1'b1 || rs1_o !== 64'h7) begin
         errs++; $display("FAIL fwd_young_done got busy=%b fwd=%b val=%h exp 0/1/7", rs1_busy_o, rs1_fwd_valid_o, rs1_o); end
      vecs++; if (rs2_busy_o !== 1'b0 || rs2_fwd_valid_o !== 1'b0) begin errs++; $display("FAIL fwd_x0 got busy=%b fwd=%b exp 0/0", rs2_busy_o, rs2_fwd_valid_o); end
   endtask

   task automatic test_flush();
      do_flush();
      for (int k = 1; k <= 4; k++) push(5'(k));
      wb(3'd0, 64'h99);
      flush_i               = 1'b1;
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i       = mk(5'd9);
      wb_valid_i            = 1'b1;
      wb_trans_id_i         = 3'd1;
      wb_result_i           = 64'h55;
      commit_ack_i          = 1'b1;
      #1;
      vecs++; if (decoded_instr_ack_o !== 1'b0) begin errs++; $display("FAIL flush_ack got=%b exp=0", decoded_instr_ack_o); end
      cyc();
      idle();
      #1;
      vecs++; if (full_o !== 1'b0 || commit_valid_o !== 1'b0 || trans_id_o !== 3'd0) begin
         errs++; $display("FAIL flush_state got full=%b cv=%b tid=%0d exp 0/0/0", full_o, commit_valid_o, trans_id_o); end
      for (int r = 1; r <= 9; r++) begin
         rs1_i = 5'(r);
         #1;
         vecs++; if (rs1_busy_o !== 1'b0 || rs1_fwd_valid_o !== 1'b0) begin errs++; $display("FAIL flush_lookup[r%0d] got busy=%b fwd=%b exp 0/0", r, rs1_busy_o, rs1_fwd_valid_o); end
      end
      rs1_i = 5'd0;
   endtask

   task automatic test_reset_mid();
      for (int k = 1; k <= 5; k++) push(5'(k));
      wb(3'd0, 64'h42);
      #1;
      vecs++; if (commit_valid_o !== 1'b1) begin errs++; $display("FAIL rstmid_pre_cv got=%b exp=1", commit_valid_o); end
      rst_ni = 1'b0;
      cyc();
      rst_ni = 1'b1;
      rs1_i  = 5'd2;
      #1;
      vecs++; if (full_o !== 1'b0 || commit_valid_o !== 1'b0 || rs1_busy_o !== 1'b0 || rs1_fwd_valid_o !== 1'b0) begin
         errs++; $display("FAIL rstmid_outputs got full=%b cv=%b busy=%b fwd=%b exp 0/0/0/0", full_o, commit_valid_o, rs1_busy_o, rs1_fwd_valid_o); end
      decoded_instr_valid_i = 1'b1;
      decoded_instr_i       = mk(5'd2);
      #1;
      vecs++; if (trans_id_o !== 3'd0 || decoded_instr_ack_o !== 1'b1) begin errs++; $display("FAIL rstmid_push got tid=%0d ack=%b exp 0/1", trans_id_o, decoded_instr_ack_o); end
      cyc();
      decoded_instr_valid_i = 1'b0;
      #1;
      vecs++; if (rs1_busy_o !== 1'b1 || trans_id_o !== 3'd1) begin errs++; $display("FAIL rstmid_after_push got busy=%b tid=%0d exp 1/1", rs1_busy_o, trans_id_o); end
   endtask

   initial begin
      rst_ni = 1'b0;
      idle();
      test_reset();
      test_push_busy();
      test_ooo_commit();
      test_full_wrap();
      test_fwd_youngest();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
